dmem_ram_bridge: RTL and testbench

//  Converts the core's data-memory request/response handshake into the data-port (port B) strobes of the

---
 rtl/dmem_bridge_pkg.sv | 47 ++++
 rtl/dmem_ram_bridge_if.sv | 31 +++
 rtl/dmem_load_align.sv | 27 ++
 rtl/dmem_ram_bridge.sv | 119 +++++++++++
 tb/tb_dmem_ram_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the data-memory to RAM port-B bridge.
// Access sizes, bridge state encoding, byte-strobe generation and
// store-data lane replication.
package dmem_bridge_pkg;

  localparam int LANE_NUM  = 4;
  localparam int LANE_BITS = 8;

  // Access size as carried on req_size; 2'd3 is the illegal encoding.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // ST_IDLE: no response held. ST_RESP: a response is presented on resp_*.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Byte write strobes for an access of the given size at byte offset off.
  function automatic logic [3:0] gen_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << off;
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Right-justified store data copied into every lane it may land in.
  function automatic logic [31:0] repl_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] word;
    word = data;
    case (size)
      SZ_BYTE: word = {4{data[7:0]}};
      SZ_HALF: word = {2{data[15:0]}};
      default: word = data;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/dmem_ram_bridge_if.sv
// Core-side data-memory request/response bundle.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The sender holds valid and its payload stable until that edge;
// ready may change freely and carries no meaning while valid is 0.
interface dmem_ram_bridge_if #(
  parameter int ADDR_BITS = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_wen;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_err;

  // Load/store unit side.
  modport master (
    output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Bridge side.
  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load lane extraction: picks the addressed byte/half/word out of the RAM
// word, moves it to the LSBs and sign- or zero-extends it.
// Used by dmem_ram_bridge only when DMEM_BRIDGE_LOAD_ALIGN_EN is defined.
module dmem_load_align
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Shift the addressed lane down, then extend from its top bit.
  always_comb begin
    shifted = word >> {off, 3'b000};
    data    = word;
    case (size)
      SZ_BYTE: data = {{24{~zext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{16{~zext & shifted[15]}}, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ram_bridge.sv
// Data-memory bridge: turns the load/store unit request/response handshake
// into port-B strobes of the shared instruction/data RAM.
// Checks range and alignment, builds byte strobes, replicates store data and
// holds each response until the consumer takes it; one access per cycle.
// Optional feature: DMEM_BRIDGE_LOAD_ALIGN_EN -- when defined, load data is
// lane-extracted and extended; otherwise the raw RAM word is returned.
module dmem_ram_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int MEM_ROW_NUM   = 4096,
  parameter int RAM_ADDR_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  dmem_ram_bridge_if.slave         bus,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [3:0]               ram_web,
  output logic [DATA_BITS-1:0]     ram_wdata,
  input  logic [DATA_BITS-1:0]     ram_q,
  output state_t                   dbg_state
);

  state_t               state;
  logic                 r_valid;
  logic                 r_err;
  logic                 r_load;
  logic [1:0]           r_off;
  logic [1:0]           r_size;
  logic                 r_zext;

  logic                 accept;
  logic                 err;
  logic [ADDR_BITS-1:0] word_idx;
  logic [31:0]          load_data;

  assign word_idx = bus.req_addr >> 2;

  // Access fault: illegal size, misalignment, or word index past the RAM.
  always_comb begin
    err = 1'b0;
    case (bus.req_size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = bus.req_addr[0];
      SZ_WORD: err = (bus.req_addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    if (word_idx >= ADDR_BITS'(MEM_ROW_NUM)) begin
      err = 1'b1;
    end
  end

  // A new request fits whenever nothing is held or the held one retires now.
  assign bus.req_ready = (state == ST_IDLE) | bus.resp_ready;
  assign accept        = bus.req_valid & bus.req_ready;

  assign ram_ren   = accept & ~bus.req_wen & ~err;
  assign ram_wen   = accept & bus.req_wen & ~err;
  assign ram_addr  = RAM_ADDR_BITS'(word_idx);
  assign ram_web   = ram_wen ? gen_strb(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
  assign ram_wdata = repl_wdata(bus.req_size, bus.req_wdata);

  // Response state machine; a new accept always wins over retiring to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_load  <= 1'b0;
      r_off   <= 2'b00;
      r_size  <= 2'b00;
      r_zext  <= 1'b0;
    end else if (accept) begin
      state   <= ST_RESP;
      r_valid <= 1'b1;
      r_err   <= err;
      r_load  <= ~bus.req_wen;
      r_off   <= bus.req_addr[1:0];
      r_size  <= bus.req_size;
      r_zext  <= bus.req_unsigned;
    end else if (state == ST_RESP && bus.resp_ready) begin
      state   <= ST_IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_load  <= 1'b0;
    end
  end

`ifdef DMEM_BRIDGE_LOAD_ALIGN_EN
  dmem_load_align u_load_align (
    .word (ram_q),
    .off  (r_off),
    .size (r_size),
    .zext (r_zext),
    .data (load_data)
  );
`else
  // The core extracts lanes itself; the registered lane info is not needed.
  logic unused_lane_info;
  assign unused_lane_info = ^{r_off, r_size, r_zext};
  assign load_data        = ram_q;
`endif

  // Load data only for an error-free load; ram_q is held while the response waits.
  always_comb begin
    bus.resp_rdata = 32'h0;
    if (r_valid && r_load && !r_err) begin
      bus.resp_rdata = load_data;
    end
  end

  assign bus.resp_valid = r_valid;
  assign bus.resp_err   = r_err;
  assign dbg_state      = state;

endmodule

// File: tb/tb_dmem_ram_bridge.sv
// Bench for dmem_ram_bridge: directed cases plus randomized traffic, with a
// byte-addressed reference memory and an expected-response queue.
module tb_dmem_ram_bridge;
  import dmem_bridge_pkg::*;

  localparam int MEM_ROW_NUM = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ram_bridge_if bus();

  logic [31:0] ram_addr;
  logic        ram_ren;
  logic        ram_wen;
  logic [3:0]  ram_web;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;
  state_t      dbg_state;

  dmem_ram_bridge #(
    .ADDR_BITS(32), .DATA_BITS(32), .MEM_ROW_NUM(MEM_ROW_NUM), .RAM_ADDR_BITS(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_web(ram_web),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .dbg_state(dbg_state)
  );

  // RAM port B: byte-strobed write, registered read held while ram_ren=0.
  logic [31:0] ram [0:MEM_ROW_NUM-1];
  always @(posedge clk) begin
    if (ram_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_web[i]) ram[ram_addr[11:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_ren) ram_q <= ram[ram_addr[11:0]];
  end

  // ---------------- reference model ----------------
  logic [7:0] mdl [0:4*MEM_ROW_NUM-1];

  function automatic logic exp_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
           ((a / 4) >= MEM_ROW_NUM);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic u);
    logic [31:0] v;
    int n;
    v = 32'h0;
`ifdef DMEM_BRIDGE_LOAD_ALIGN_EN
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a + i];
    if (!u && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
`else
    n = int'(a & 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mdl[n + i];
    if (u || sz == 2'd3) v = v;
`endif
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          pop_cyc[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          last_wait;
  logic [32:0] mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: a response transfers where resp_valid and resp_ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b expected no response",
                 bus.resp_rdata, bus.resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, mon_e[32]});
        check("resp_rdata", bus.resp_rdata, mon_e[31:0]);
      end
      pop_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] d);
    logic        err;
    logic [3:0]  web;
    logic [31:0] wd;
    int          n;
    bit          ok;
    bus.req_valid    = 1'b1;
    bus.req_addr     = a;
    bus.req_wen      = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_wdata    = d;
    ok        = 1'b0;
    last_wait = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      last_wait++;
      check("stall_strobes", {30'b0, ram_ren, ram_wen}, 32'd0);
    end
    if (!ok) begin
      n_total++;
      n_bad++;
      $display("FAIL req_timeout: addr=%h never accepted, expected acceptance", a);
    end else begin
      err = exp_err(a, sz);
      check("ram_ren", {31'b0, ram_ren}, {31'b0, !w && !err});
      check("ram_wen", {31'b0, ram_wen}, {31'b0, w && !err});
      if (!err) check("ram_addr", ram_addr, a >> 2);
      if (w && !err) begin
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        web = 4'b0000;
        wd  = 32'h0;
        for (int i = 0; i < n; i++) web[int'(a[1:0]) + i] = 1'b1;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % n) +: 8];
        check("ram_web", {28'b0, ram_web}, {28'b0, web});
        check("ram_wdata", ram_wdata, wd);
        for (int i = 0; i < n; i++) mdl[a + i] = d[8*i +: 8];
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        check("ram_web_idle", {28'b0, ram_web}, 32'd0);
        if (err || w) exp_q.push_back({err, 32'h0});
        else          exp_q.push_back({1'b0, exp_load(a, sz, u)});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  // Random backpressure on resp_ready while enabled.
  bit rnd_ready_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready_en) bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ra;
  logic [1:0]  rs;
  logic [31:0] hold_val;

  initial begin
    for (int i = 0; i < MEM_ROW_NUM; i++) ram[i] = 32'h0;
    for (int i = 0; i < 4*MEM_ROW_NUM; i++) mdl[i] = 8'h0;
    ram_q            = 32'h0;
    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wen      = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b1;
    rst              = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_state", {31'b0, dbg_state}, {31'b0, ST_IDLE});
    check("rst_strobes", {30'b0, ram_ren, ram_wen}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: word store then word load
    issue(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(2);

    // 2: byte store into the top lane, then reads
    issue(32'h13, 1'b1, 2'd0, 1'b0, 32'h000000A5);
    issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    issue(32'h13, 1'b0, 2'd0, 1'b0, 32'h0);
    issue(32'h13, 1'b0, 2'd0, 1'b1, 32'h0);
    issue(32'h12, 1'b0, 2'd1, 1'b0, 32'h0);
    idle(2);

    // 3: faults
    issue(32'h11, 1'b0, 2'd1, 1'b0, 32'h0);
    issue(32'h12, 1'b0, 2'd2, 1'b0, 32'h0);
    issue(32'h10, 1'b0, 2'd3, 1'b0, 32'h0);
    issue(32'h10, 1'b1, 2'd3, 1'b0, 32'h1);
    issue(32'(4*MEM_ROW_NUM), 1'b0, 2'd2, 1'b0, 32'h0);
    issue(32'(4*MEM_ROW_NUM - 4), 1'b1, 2'd2, 1'b0, 32'h0BAD_F00D);
    issue(32'(4*MEM_ROW_NUM - 4), 1'b0, 2'd2, 1'b0, 32'h0);
    idle(2);

    // 4: back-to-back loads with resp_ready held
    pop_cyc.delete();
    issue(32'h0, 1'b0, 2'd2, 1'b0, 32'h0);
    check("b2b_wait0", 32'(last_wait), 32'd0);
    issue(32'h4, 1'b0, 2'd2, 1'b0, 32'h0);
    check("b2b_wait1", 32'(last_wait), 32'd0);
    issue(32'h8, 1'b0, 2'd2, 1'b0, 32'h0);
    check("b2b_wait2", 32'(last_wait), 32'd0);
    idle(3);
    check("b2b_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("b2b_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end

    // 5: response held under backpressure
    issue(32'h4, 1'b1, 2'd2, 1'b0, 32'h12345678);
    idle(1);
    bus.resp_ready = 1'b0;
    issue(32'h4, 1'b0, 2'd2, 1'b0, 32'h0);
    hold_val = exp_load(32'h4, 2'd2, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    bus.req_wen   = 1'b0;
    bus.req_size  = 2'd2;
    repeat (5) begin
      @(negedge clk);
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("hold_ram_ren", {31'b0, ram_ren}, 32'd0);
      check("hold_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("hold_rdata", bus.resp_rdata, hold_val);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    issue(32'h8, 1'b0, 2'd2, 1'b0, 32'h0);
    check("release_wait", 32'(last_wait), 32'd0);
    idle(2);

    // 6: reset while a store response is held
    bus.resp_ready = 1'b0;
    issue(32'h20, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D);
    bus.req_valid = 1'b0;
    check("pre_rst_valid", {31'b0, bus.resp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("async_rst_state", {31'b0, dbg_state}, {31'b0, ST_IDLE});
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    issue(32'h20, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(2);

    // Random traffic with random backpressure
    rnd_ready_en = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else                           ra = 32'($urandom_range(0, 63));
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      issue(ra, 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_ready_en = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drain();
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
